// File: rtl/link_dest_pipe.sv
// Resolves the Execute destination for link-type ops and carries it through
// DEPTH post-Execute slots with hazard match flags. Option: LINK_ZERO_SUPPRESS_EN.
`ifndef EXE_JAL_OP
`define EXE_JAL_OP 8'h50
`endif
`ifndef EXE_JALR_OP
`define EXE_JALR_OP 8'h51
`endif
`ifndef EXE_BGEZAL_OP
`define EXE_BGEZAL_OP 8'h52
`endif
`ifndef EXE_BLTZAL_OP
`define EXE_BLTZAL_OP 8'h53
`endif

module link_dest_pipe #(
  parameter int REG_AW   = 5,
  parameter int LINK_REG = 31,
  parameter int OP_W     = 8,
  parameter int DEPTH    = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              valid_e,
  input  logic [OP_W-1:0]   alucontrol_e,
  input  logic [REG_AW-1:0] writereg_e,
  input  logic              regwrite_e,
  input  logic [31:0]       pc_e,
  input  logic              advance,
  input  logic              flush,
  input  logic [REG_AW-1:0] rs_q,
  input  logic [REG_AW-1:0] rt_q,
  output logic [REG_AW-1:0] writereg_res_e,
  output logic              wb_valid,
  output logic              wb_we,
  output logic              wb_link,
  output logic [REG_AW-1:0] wb_reg,
  output logic [31:0]       wb_link_data,
  output logic [DEPTH-1:0]  hit_rs,
  output logic [DEPTH-1:0]  hit_rt,
  output logic [DEPTH-1:0]  fwd_rs,
  output logic [DEPTH-1:0]  fwd_rt
);

  localparam logic [OP_W-1:0] JAL_OP    = OP_W'(`EXE_JAL_OP);
  localparam logic [OP_W-1:0] JALR_OP   = OP_W'(`EXE_JALR_OP);
  localparam logic [OP_W-1:0] BGEZAL_OP = OP_W'(`EXE_BGEZAL_OP);
  localparam logic [OP_W-1:0] BLTZAL_OP = OP_W'(`EXE_BLTZAL_OP);
  localparam logic [REG_AW-1:0] LREG    = REG_AW'(LINK_REG);

  logic              is_link;
  logic [REG_AW-1:0] res_reg;
  logic              res_we;
  logic [31:0]       res_data;
  logic              live;
  logic              rs_ok;
  logic              rt_ok;

  logic [DEPTH-1:0]  v_q;
  logic [DEPTH-1:0]  we_q;
  logic [DEPTH-1:0]  lk_q;
  logic [REG_AW-1:0] rg_q [DEPTH];
  logic [31:0]       dt_q [DEPTH];

  // Destination and write-enable resolution for the instruction in Execute
  always_comb begin
    is_link = 1'b0;
    res_reg = writereg_e;
    unique case (1'b1)
      (alucontrol_e == JAL_OP),
      (alucontrol_e == BGEZAL_OP),
      (alucontrol_e == BLTZAL_OP): begin
        is_link = 1'b1;
        res_reg = LREG;
      end
      (alucontrol_e == JALR_OP): begin
        is_link = 1'b1;
        res_reg = (writereg_e == '0) ? LREG : writereg_e;
      end
      default: begin
        is_link = 1'b0;
        res_reg = writereg_e;
      end
    endcase
`ifdef LINK_ZERO_SUPPRESS_EN
    res_we = is_link | (regwrite_e & (res_reg != '0));
`else
    res_we = is_link | regwrite_e;
`endif
  end

  assign res_data       = pc_e + 32'd8;
  assign live           = valid_e & ~flush;
  assign writereg_res_e = res_reg;

`ifdef LINK_ZERO_SUPPRESS_EN
  assign rs_ok = (rs_q != '0);
  assign rt_ok = (rt_q != '0);
`else
  assign rs_ok = 1'b1;
  assign rt_ok = 1'b1;
`endif

  // Slot shift register: slot 0 takes Execute or a bubble, the rest shift
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      v_q  <= '0;
      we_q <= '0;
      lk_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        rg_q[k] <= '0;
        dt_q[k] <= '0;
      end
    end else begin
      if (advance | flush) begin
        v_q[0]  <= live;
        we_q[0] <= live & res_we;
        lk_q[0] <= live & is_link;
        rg_q[0] <= live ? res_reg : '0;
        dt_q[0] <= (live & is_link) ? res_data : '0;
      end
      if (advance) begin
        for (int k = 1; k < DEPTH; k++) begin
          v_q[k]  <= v_q[k-1];
          we_q[k] <= we_q[k-1];
          lk_q[k] <= lk_q[k-1];
          rg_q[k] <= rg_q[k-1];
          dt_q[k] <= dt_q[k-1];
        end
      end
    end
  end

  // Per-slot source matches against live writing entries
  always_comb begin
    hit_rs = '0;
    hit_rt = '0;
    for (int k = 0; k < DEPTH; k++) begin
      hit_rs[k] = v_q[k] & we_q[k] & (rg_q[k] == rs_q) & rs_ok;
      hit_rt[k] = v_q[k] & we_q[k] & (rg_q[k] == rt_q) & rt_ok;
    end
  end

  assign fwd_rs = hit_rs & (~hit_rs + 1'b1);
  assign fwd_rt = hit_rt & (~hit_rt + 1'b1);

  assign wb_valid     = v_q[DEPTH-1];
  assign wb_we        = we_q[DEPTH-1];
  assign wb_link      = lk_q[DEPTH-1];
  assign wb_reg       = rg_q[DEPTH-1];
  assign wb_link_data = dt_q[DEPTH-1];

endmodule

// File: tb/tb_link_dest_pipe.sv
// Bench for link_dest_pipe: directed cases plus randomized traffic
// checked against a slot-array reference model.
module tb_link_dest_pipe;

  localparam int D = 2;
  localparam logic [7:0] OP_JAL    = 8'h50;
  localparam logic [7:0] OP_JALR   = 8'h51;
  localparam logic [7:0] OP_BGEZAL = 8'h52;
  localparam logic [7:0] OP_BLTZAL = 8'h53;
  localparam logic [7:0] OP_ADD    = 8'h20;
  localparam logic [7:0] OP_LW     = 8'h30;

  typedef struct packed {
    logic        v;
    logic        we;
    logic        lk;
    logic [4:0]  r;
    logic [31:0] d;
  } ent_t;

  logic clk = 0;
  logic resetn = 0;
  logic valid_e = 0;
  logic [7:0] alucontrol_e = OP_ADD;
  logic [4:0] writereg_e = 0;
  logic regwrite_e = 0;
  logic [31:0] pc_e = 0;
  logic advance = 0;
  logic flush = 0;
  logic [4:0] rs_q = 0;
  logic [4:0] rt_q = 0;
  logic [4:0] writereg_res_e;
  logic wb_valid, wb_we, wb_link;
  logic [4:0] wb_reg;
  logic [31:0] wb_link_data;
  logic [D-1:0] hit_rs, hit_rt, fwd_rs, fwd_rt;

  int n_chk = 0;
  int n_fail = 0;
  ent_t m [D];

  link_dest_pipe #(.DEPTH(D)) dut (
    .clk(clk), .resetn(resetn), .valid_e(valid_e),
    .alucontrol_e(alucontrol_e), .writereg_e(writereg_e),
    .regwrite_e(regwrite_e), .pc_e(pc_e), .advance(advance),
    .flush(flush), .rs_q(rs_q), .rt_q(rt_q),
    .writereg_res_e(writereg_res_e), .wb_valid(wb_valid),
    .wb_we(wb_we), .wb_link(wb_link), .wb_reg(wb_reg),
    .wb_link_data(wb_link_data), .hit_rs(hit_rs), .hit_rt(hit_rt),
    .fwd_rs(fwd_rs), .fwd_rt(fwd_rt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic ent_t ref_ent();
    ent_t e;
    bit link;
    e = '0;
    if (!valid_e || flush) return e;
    link = (alucontrol_e == OP_JAL) || (alucontrol_e == OP_JALR) ||
           (alucontrol_e == OP_BGEZAL) || (alucontrol_e == OP_BLTZAL);
    e.v = 1;
    e.lk = link;
    if (link && (alucontrol_e != OP_JALR || writereg_e == 0)) e.r = 5'd31;
    else e.r = writereg_e;
    e.we = link || regwrite_e;
`ifdef LINK_ZERO_SUPPRESS_EN
    if (!link && e.r == 0) e.we = 0;
`endif
    if (link) e.d = pc_e + 32'd8;
    return e;
  endfunction

  function automatic logic [4:0] ref_res();
    if (alucontrol_e == OP_JAL || alucontrol_e == OP_BGEZAL ||
        alucontrol_e == OP_BLTZAL) return 5'd31;
    if (alucontrol_e == OP_JALR && writereg_e == 0) return 5'd31;
    return writereg_e;
  endfunction

  function automatic logic [D-1:0] ref_hit(input logic [4:0] q);
    logic [D-1:0] h = '0;
    for (int k = 0; k < D; k++) begin
      h[k] = m[k].v && m[k].we && (m[k].r == q);
`ifdef LINK_ZERO_SUPPRESS_EN
      if (q == 0) h[k] = 0;
`endif
    end
    return h;
  endfunction

  function automatic logic [D-1:0] ref_fwd(input logic [D-1:0] h);
    logic [D-1:0] f = '0;
    for (int k = 0; k < D; k++)
      if (h[k]) begin
        f[k] = 1;
        break;
      end
    return f;
  endfunction

  task automatic chk_comb();
    chk("res", 32'(writereg_res_e), 32'(ref_res()));
    chk("hit_rs", 32'(hit_rs), 32'(ref_hit(rs_q)));
    chk("hit_rt", 32'(hit_rt), 32'(ref_hit(rt_q)));
    chk("fwd_rs", 32'(fwd_rs), 32'(ref_fwd(ref_hit(rs_q))));
    chk("fwd_rt", 32'(fwd_rt), 32'(ref_fwd(ref_hit(rt_q))));
  endtask

  task automatic chk_wb();
    chk("wb_valid", 32'(wb_valid), 32'(m[D-1].v));
    chk("wb_we", 32'(wb_we), 32'(m[D-1].we));
    chk("wb_link", 32'(wb_link), 32'(m[D-1].lk));
    chk("wb_reg", 32'(wb_reg), 32'(m[D-1].r));
    chk("wb_data", wb_link_data, m[D-1].d);
  endtask

  task automatic cyc();
    ent_t n;
    #1;
    chk_comb();
    n = ref_ent();
    @(posedge clk);
    if (advance) for (int k = D - 1; k > 0; k--) m[k] = m[k-1];
    if (advance || flush) m[0] = n;
    #1;
    chk_wb();
  endtask

  task automatic put(input logic [7:0] op, input logic [4:0] rd,
                     input logic rw, input logic [31:0] pc);
    valid_e = 1;
    alucontrol_e = op;
    writereg_e = rd;
    regwrite_e = rw;
    pc_e = pc;
    advance = 1;
    flush = 0;
  endtask

  task automatic model_clear();
    for (int k = 0; k < D; k++) m[k] = '0;
  endtask

  logic [7:0] ops [6];
  ent_t held;

  initial begin
    ops[0] = OP_JAL; ops[1] = OP_JALR; ops[2] = OP_BGEZAL;
    ops[3] = OP_BLTZAL; ops[4] = OP_ADD; ops[5] = OP_LW;
    model_clear();
    #3;
    chk("rst_valid", 32'(wb_valid), 0);
    chk("rst_data", wb_link_data, 0);
    chk("rst_hit", 32'(hit_rs), 0);
    @(negedge clk);
    resetn = 1;
    @(posedge clk);
    #1;

    put(OP_JALR, 5'd0, 1'b0, 32'h0040_0010);
    #1;
    chk("jalr_res0", 32'(writereg_res_e), 31);
    cyc();
    valid_e = 0;
    cyc();
    chk("jalr_wbreg", 32'(wb_reg), 31);
    chk("jalr_wbwe", 32'(wb_we), 1);
    chk("jalr_wblink", 32'(wb_link), 1);
    chk("jalr_wbdata", wb_link_data, 32'h0040_0018);

    put(OP_JALR, 5'd5, 1'b1, 32'h100);
    cyc();
    put(OP_BGEZAL, 5'd0, 1'b0, 32'h104);
    cyc();
    valid_e = 0;
    advance = 0;
    rs_q = 5'd31;
    #1;
    chk("link_hit_rs", 32'(hit_rs), 32'b01);
    chk("link_fwd_rs", 32'(fwd_rs), 32'b01);
    chk("link_wbreg", 32'(wb_reg), 5);

    put(OP_ADD, 5'd7, 1'b1, 32'h200);
    cyc();
    put(OP_LW, 5'd7, 1'b1, 32'h204);
    cyc();
    valid_e = 0;
    advance = 0;
    rt_q = 5'd7;
    #1;
    chk("raw_hit_rt", 32'(hit_rt), 32'b11);
    chk("raw_fwd_rt", 32'(fwd_rt), 32'b01);

    held = m[D-1];
    put(OP_ADD, 5'd9, 1'b1, 32'h300);
    advance = 0;
    flush = 1;
    cyc();
    flush = 0;
    cyc();
    cyc();
    chk("stall_wbreg", 32'(wb_reg), 32'(held.r));
    chk("stall_wbvalid", 32'(wb_valid), 32'(held.v));
    chk("stall_bubble", 32'(hit_rt), 32'b10);

    put(OP_JAL, 5'd3, 1'b0, 32'hFFFF_FFFC);
    cyc();
    valid_e = 0;
    cyc();
    chk("wrap_data", wb_link_data, 32'h0000_0004);
    rs_q = 5'd31;
    #2;
    resetn = 0;
    model_clear();
    #1;
    chk("arst_valid", 32'(wb_valid), 0);
    chk("arst_we", 32'(wb_we), 0);
    chk("arst_link", 32'(wb_link), 0);
    chk("arst_data", wb_link_data, 0);
    chk("arst_hit", 32'(hit_rs), 0);
    @(negedge clk);
    resetn = 1;
    @(posedge clk);
    #1;

    put(OP_ADD, 5'd0, 1'b1, 32'h400);
    rs_q = 5'd0;
    cyc();
    valid_e = 0;
    advance = 0;
    #1;
`ifdef LINK_ZERO_SUPPRESS_EN
    chk("r0_hit", 32'(hit_rs), 0);
`else
    chk("r0_hit", 32'(hit_rs), 32'b01);
`endif
    advance = 1;
    cyc();
`ifdef LINK_ZERO_SUPPRESS_EN
    chk("r0_wbwe", 32'(wb_we), 0);
`else
    chk("r0_wbwe", 32'(wb_we), 1);
`endif

    for (int i = 0; i < 400; i++) begin
      valid_e = ($urandom_range(0, 4) != 0);
      alucontrol_e = ops[$urandom_range(0, 5)];
      writereg_e = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) writereg_e = 5'd31;
      regwrite_e = 1'($urandom_range(0, 1));
      pc_e = {$urandom(), 2'b00} >> 0;
      pc_e[1:0] = 2'b00;
      if ($urandom_range(0, 15) == 0) pc_e = 32'hFFFF_FFFC;
      advance = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 5) == 0);
      rs_q = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      rt_q = 5'($urandom_range(0, 7));
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
